scan_chain_loader: RTL and testbench
====================================

# scan_chain_loader

Drives the weight/bias scan chain of a neuron layer from the head end. In LOAD mode it pulls `ChainLength` words from an upstream valid/ready stream and shifts them into the chain. In ROTATE mode it recirculates the chain tail back into the head, which reads the contents out without destroying them. In both modes, every word leaving the chain tail is returned on a readback stream. It sits between the training/configuration controller and the `shift`/`scan` pins of the first neuron; the last neuron's scan output returns to it.

## Interface
- `DataWidth`, 8: width of one scan word; equals the neurons' weight width.
- `ChainLength`, 6: total word registers in the chain, including each neuron's scan output register; per neuron this is NumInputs+2. Must be ≥1.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  single-cycle start request; ignored unless idle.
- `mode_i`  in  1  sampled with `start_i`: 0 = LOAD, 1 = ROTATE.
- `busy_o`  out  1  high from the cycle after an accepted start until `done_o`, inclusive.
- `done_o`  out  1  one-cycle pulse at completion.
- `in_valid_i`  in  1  upstream word valid (LOAD only).
- `in_data_i`  in  DataWidth  upstream word.
- `in_ready_o`  out  1  upstream word consumed this cycle.
- `rd_valid_o`  out  1  readback word valid.
- `rd_data_o`  out  DataWidth  readback word (chain tail value).
- `rd_ready_i`  in  1  readback consumer ready.
- `shift_o`  out  1  chain shift enable, to every neuron.
- `scan_o`  out  DataWidth  chain head data.
- `scan_i`  in  DataWidth  chain tail data.

## Operation
- FSM states: ST_IDLE, ST_SHIFT, ST_DRAIN, ST_DONE.
- ST_IDLE → ST_SHIFT on `start_i`. On that transition, latch `mode_i` into `mode_q` and clear the word counter `cnt`. The counter is $clog2(ChainLength+1) bits.
- ST_SHIFT behaviour:
  - `src_ok` = `mode_q` ? 1 : `in_valid_i`.
  - `rd_ok` = !`rd_valid_o` || `rd_ready_i`.
  - `shift_o` = `src_ok` && `rd_ok`. This is combinational and is 0 in all other states.
  - `scan_o` = `mode_q` ? `scan_i` : `in_data_i`. This is combinational; its value is don't-care when `shift_o`=0.
  - `in_ready_o` = `shift_o` && !`mode_q`.
  - On each edge with `shift_o`=1: `rd_data_o` ← `scan_i` (the tail value before it updates), `rd_valid_o` ← 1, `cnt` ← `cnt`+1.
  - When the shift that makes `cnt`=ChainLength occurs, go to ST_DRAIN.
- `rd_valid_o` clears on an edge where `rd_ready_i`=1 and no new capture occurs.
- ST_DRAIN: wait until `rd_valid_o`=0, or `rd_valid_o`&&`rd_ready_i`. Then go to ST_DONE.
- ST_DONE: `done_o`=1 for one cycle, then go to ST_IDLE.
- Readback order: the first `rd_data_o` is the word held in the tail register at start, i.e. tail first. In LOAD, the first accepted input word ends in the register farthest from the head.
- ROTATE with ChainLength shifts leaves the chain contents unchanged.
- Shift cycles need not be contiguous. A gap occurs whenever `src_ok` or `rd_ok` is low. Neurons see `shift_o`=0 during gaps; the controller keeps the layer's forward request inputs idle while `busy_o`=1.

## Timing
- Reset (any state, including mid-shift): `shift_o`=0, `in_ready_o`=0, `rd_valid_o`=0, `rd_data_o`=0, `busy_o`=0, `done_o`=0, state ST_IDLE, `cnt`=0, `mode_q`=0. Words already shifted stay in the chain; the loader does not restore them.
- `start_i` edge t: the first possible `shift_o` is in cycle t+1.
- With upstream always valid and `rd_ready_i`=1:
  - `shift_o` is high for cycles t+1 … t+ChainLength.
  - ST_DRAIN is in cycle t+ChainLength+1; it exits immediately because `rd_ready_i`=1.
  - `done_o` is high in cycle t+ChainLength+2.
- A readback word is visible the cycle after its capture shift.
- Simultaneous consume and capture on the same edge keeps `rd_valid_o`=1 with the new data.
- `start_i` while `busy_o`=1 is ignored, and `mode_q` is unchanged.

## Test plan
- LOAD, ChainLength=6, chain model initialised to 0xA0..0xA5 (tail=0xA5), inputs 0x10..0x15, ready always 1 → `shift_o` high for 6 consecutive cycles, readback 0xA5,0xA4,…,0xA0. Chain then holds 0x15 at head … 0x10 at tail. `done_o` pulses 8 cycles after start.
- ROTATE on the chain from the previous test → readback 0x10,0x11,…,0x15; chain contents unchanged afterwards; `in_ready_o` never asserted.
- LOAD with `in_valid_i` dropped for 3 cycles after word 2 → `shift_o` gaps for exactly those 3 cycles, final contents identical to the first test, `done_o` 3 cycles later.
- `rd_ready_i`=0 for 4 cycles mid-load → at most one shift occurs while `rd_valid_o` is held; no readback word is lost or duplicated.
- `reset_i` asserted after 3 shifts → next cycle all outputs 0 and `busy_o`=0. A fresh LOAD then completes normally in 6 shifts.
- `start_i` pulsed again during ST_SHIFT with `mode_i` toggled → ignored; exactly 6 shifts and one `done_o`.

Source files
------------

// File: rtl/scan_chain_loader_if.sv
// Handshake and chain-pin bundle between the scan chain loader and its surroundings.
// Signal suffixes are from the loader's point of view.
interface scan_chain_loader_if #(
  parameter int unsigned DataWidth = 8
);
  logic                 start_i;
  logic                 mode_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 in_valid_i;
  logic [DataWidth-1:0] in_data_i;
  logic                 in_ready_o;
  logic                 rd_valid_o;
  logic [DataWidth-1:0] rd_data_o;
  logic                 rd_ready_i;
  logic                 shift_o;
  logic [DataWidth-1:0] scan_o;
  logic [DataWidth-1:0] scan_i;

  modport slave (
    input  start_i, mode_i, in_valid_i, in_data_i, rd_ready_i, scan_i,
    output busy_o, done_o, in_ready_o, rd_valid_o, rd_data_o, shift_o, scan_o
  );

  modport master (
    output start_i, mode_i, in_valid_i, in_data_i, rd_ready_i, scan_i,
    input  busy_o, done_o, in_ready_o, rd_valid_o, rd_data_o, shift_o, scan_o
  );
endinterface

// File: rtl/scan_chain_loader.sv
// Head-end driver for a neuron layer's weight/bias scan chain: LOAD shifts in upstream
// words, ROTATE recirculates the tail; every word leaving the tail is returned on readback.
module scan_chain_loader #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned ChainLength = 6
) (
  input logic                clk_i,
  input logic                reset_i,
  scan_chain_loader_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(ChainLength + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(ChainLength - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e               state_q;
  logic                 mode_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rd_valid_q;
  logic [DataWidth-1:0] rd_data_q;

  logic src_ok;
  logic rd_ok;
  logic shift;

  // A shift needs a source word and room in the readback register for the outgoing tail word.
  always_comb begin
    src_ok = mode_q | bus.in_valid_i;
    rd_ok  = !rd_valid_q || bus.rd_ready_i;
    shift  = (state_q == ST_SHIFT) && src_ok && rd_ok;
  end

  assign bus.shift_o    = shift;
  assign bus.scan_o     = mode_q ? bus.scan_i : bus.in_data_i;
  assign bus.in_ready_o = shift && !mode_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_q <= 1'b0;

      // Capture the tail before it moves; a consume without capture empties the register.
      if (shift) begin
        rd_data_q  <= bus.scan_i;
        rd_valid_q <= 1'b1;
        cnt_q      <= cnt_q + 1'b1;
      end else if (bus.rd_ready_i) begin
        rd_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_q <= ST_SHIFT;
            mode_q  <= bus.mode_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift && (cnt_q == LastIdx)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!rd_valid_q || bus.rd_ready_i) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader with a 6-word chain model hanging off shift_o/scan_o.
module tb_scan_chain_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned CL = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scan_chain_loader_if #(.DataWidth(DW)) bus ();

  scan_chain_loader #(
    .DataWidth  (DW),
    .ChainLength(CL)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  // Chain model: index 0 is the head, CL-1 the tail.
  logic [DW-1:0] chain [CL];
  logic          preset_req = 1'b0;
  logic          sh_n       = 1'b0;
  logic [DW-1:0] sc_n       = '0;

  always @(negedge clk) begin
    sh_n <= bus.shift_o;
    sc_n <= bus.scan_o;
  end

  always @(posedge clk) begin
    if (preset_req) begin
      for (int k = 0; k < CL; k++) chain[k] <= DW'(8'hA0 + k);
    end else if (sh_n) begin
      for (int k = CL - 1; k > 0; k--) chain[k] <= chain[k-1];
      chain[0] <= sc_n;
    end
  end

  assign bus.scan_i = chain[CL-1];

  int n_checks = 0;
  int n_fail   = 0;

  int            shift_q [$];
  logic [DW-1:0] rb_q    [$];
  int            done_cyc;
  int            done_cnt;
  int            inrdy_cnt;
  int            busy_err;
  bit            timed_out;
  logic          rs_busy, rs_done, rs_shift, rs_inrdy, rs_rdv;
  logic [DW-1:0] rs_rdd;

  task automatic preset_chain();
    preset_req = 1'b1;
    @(posedge clk); #1;
    preset_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one operation; cycle 0 is the cycle start_i is high, results land in the globals.
  task automatic run_op(input logic mode, input int gap_after, input int gap_len,
                        input int stall_start, input int stall_len,
                        input int rst_after, input bit restart);
    int            cyc       = 0;
    int            idx       = 0;
    int            gap_used  = 0;
    bit            fin       = 0;
    bit            rst_fired = 0;
    logic [DW-1:0] feed [CL];
    for (int k = 0; k < CL; k++) feed[k] = DW'(8'h10 + k);
    shift_q.delete();
    rb_q.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    inrdy_cnt = 0;
    busy_err  = 0;
    timed_out = 0;
    @(posedge clk); #1;
    bus.start_i    = 1'b1;
    bus.mode_i     = mode;
    bus.in_valid_i = !mode;
    bus.in_data_i  = feed[0];
    bus.rd_ready_i = 1'b1;
    while (!fin) begin
      @(negedge clk);
      if (rst_fired && !reset) begin
        rs_busy  = bus.busy_o;
        rs_done  = bus.done_o;
        rs_shift = bus.shift_o;
        rs_inrdy = bus.in_ready_o;
        rs_rdv   = bus.rd_valid_o;
        rs_rdd   = bus.rd_data_o;
        fin      = 1;
      end else begin
        if (bus.busy_o !== (cyc >= 1)) busy_err++;
        if (bus.shift_o) shift_q.push_back(cyc);
        if (bus.in_ready_o) begin
          idx++;
          inrdy_cnt++;
        end
        if (bus.rd_valid_o && bus.rd_ready_i) rb_q.push_back(bus.rd_data_o);
        if (bus.done_o) begin
          done_cnt++;
          done_cyc = cyc;
          fin      = 1;
        end
      end
      if (!fin && cyc >= 60) begin
        timed_out = 1;
        fin       = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
        bus.start_i    = restart && (cyc == 2);
        bus.mode_i     = restart ? !mode : mode;
        bus.in_valid_i = !mode;
        if (gap_after >= 0 && idx == gap_after && gap_used < gap_len) begin
          bus.in_valid_i = 1'b0;
          gap_used++;
        end
        bus.in_data_i  = (idx < CL) ? feed[idx] : '0;
        bus.rd_ready_i = !(stall_start >= 0 && cyc >= stall_start && cyc < stall_start + stall_len);
        if (rst_after >= 0 && !rst_fired && shift_q.size() == rst_after) begin
          reset     = 1'b1;
          rst_fired = 1;
        end else begin
          reset = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    reset          = 1'b0;
    bus.start_i    = 1'b0;
    bus.mode_i     = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.rd_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    preset_chain();
    @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_checks++; if (bus.shift_o !== 1'b0) begin n_fail++; $display("FAIL reset_shift: got %b want 0", bus.shift_o); end
    n_checks++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready_o); end
    n_checks++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid_o); end
    n_checks++; if (bus.rd_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data_o); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_load();
    int exp_sh [6] = '{1, 2, 3, 4, 5, 6};
    preset_chain();
    run_op(1'b0, -1, 0, -1, 0, -1, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL load_timeout: got %b want 0", timed_out); end
    n_checks++; if (shift_q.size() !== 6) begin n_fail++; $display("FAIL load_shift_count: got %0d want 6", shift_q.size()); end
    for (int k = 0; k < 6; k++) begin
      int g = (k < shift_q.size()) ? shift_q[k] : -1;
      n_checks++; if (g !== exp_sh[k]) begin n_fail++; $display("FAIL load_shift_cycle[%0d]: got %0d want %0d", k, g, exp_sh[k]); end
    end
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] g = (k < rb_q.size()) ? rb_q[k] : 'x;
      n_checks++; if (g !== DW'(8'hA5 - k)) begin n_fail++; $display("FAIL load_readback[%0d]: got %h want %h", k, g, DW'(8'hA5 - k)); end
    end
    for (int k = 0; k < CL; k++) begin
      n_checks++; if (chain[k] !== DW'(8'h15 - k)) begin n_fail++; $display("FAIL load_chain[%0d]: got %h want %h", k, chain[k], DW'(8'h15 - k)); end
    end
    n_checks++; if (done_cyc !== 8) begin n_fail++; $display("FAIL load_done_cycle: got %0d want 8", done_cyc); end
    n_checks++; if (inrdy_cnt !== 6) begin n_fail++; $display("FAIL load_in_ready_count: got %0d want 6", inrdy_cnt); end
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL load_busy_window: got %0d bad cycles want 0", busy_err); end
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse: got %b want 0", bus.done_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL load_busy_after: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_rotate();
    run_op(1'b1, -1, 0, -1, 0, -1, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rot_timeout: got %b want 0", timed_out); end
    n_checks++; if (shift_q.size() !== 6) begin n_fail++; $display("FAIL rot_shift_count: got %0d want 6", shift_q.size()); end
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] g = (k < rb_q.size()) ? rb_q[k] : 'x;
      n_checks++; if (g !== DW'(8'h10 + k)) begin n_fail++; $display("FAIL rot_readback[%0d]: got %h want %h", k, g, DW'(8'h10 + k)); end
    end
    for (int k = 0; k < CL; k++) begin
      n_checks++; if (chain[k] !== DW'(8'h15 - k)) begin n_fail++; $display("FAIL rot_chain[%0d]: got %h want %h", k, chain[k], DW'(8'h15 - k)); end
    end
    n_checks++; if (inrdy_cnt !== 0) begin n_fail++; $display("FAIL rot_in_ready_count: got %0d want 0", inrdy_cnt); end
    n_checks++; if (done_cyc !== 8) begin n_fail++; $display("FAIL rot_done_cycle: got %0d want 8", done_cyc); end
  endtask

  task automatic test_gap();
    int exp_sh [6] = '{1, 2, 6, 7, 8, 9};
    preset_chain();
    run_op(1'b0, 2, 3, -1, 0, -1, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL gap_timeout: got %b want 0", timed_out); end
    n_checks++; if (shift_q.size() !== 6) begin n_fail++; $display("FAIL gap_shift_count: got %0d want 6", shift_q.size()); end
    for (int k = 0; k < 6; k++) begin
      int g = (k < shift_q.size()) ? shift_q[k] : -1;
      n_checks++; if (g !== exp_sh[k]) begin n_fail++; $display("FAIL gap_shift_cycle[%0d]: got %0d want %0d", k, g, exp_sh[k]); end
    end
    for (int k = 0; k < CL; k++) begin
      n_checks++; if (chain[k] !== DW'(8'h15 - k)) begin n_fail++; $display("FAIL gap_chain[%0d]: got %h want %h", k, chain[k], DW'(8'h15 - k)); end
    end
    n_checks++; if (done_cyc !== 11) begin n_fail++; $display("FAIL gap_done_cycle: got %0d want 11", done_cyc); end
  endtask

  task automatic test_stall();
    int exp_sh [6] = '{1, 2, 7, 8, 9, 10};
    preset_chain();
    run_op(1'b0, -1, 0, 3, 4, -1, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %b want 0", timed_out); end
    n_checks++; if (shift_q.size() !== 6) begin n_fail++; $display("FAIL stall_shift_count: got %0d want 6", shift_q.size()); end
    for (int k = 0; k < 6; k++) begin
      int g = (k < shift_q.size()) ? shift_q[k] : -1;
      n_checks++; if (g !== exp_sh[k]) begin n_fail++; $display("FAIL stall_shift_cycle[%0d]: got %0d want %0d", k, g, exp_sh[k]); end
    end
    n_checks++; if (rb_q.size() !== 6) begin n_fail++; $display("FAIL stall_readback_count: got %0d want 6", rb_q.size()); end
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] g = (k < rb_q.size()) ? rb_q[k] : 'x;
      n_checks++; if (g !== DW'(8'hA5 - k)) begin n_fail++; $display("FAIL stall_readback[%0d]: got %h want %h", k, g, DW'(8'hA5 - k)); end
    end
    n_checks++; if (done_cyc !== 12) begin n_fail++; $display("FAIL stall_done_cycle: got %0d want 12", done_cyc); end
  endtask

  task automatic test_reset_mid();
    preset_chain();
    run_op(1'b0, -1, 0, -1, 0, 3, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout: got %b want 0", timed_out); end
    n_checks++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", rs_busy); end
    n_checks++; if (rs_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", rs_done); end
    n_checks++; if (rs_shift !== 1'b0) begin n_fail++; $display("FAIL rstmid_shift: got %b want 0", rs_shift); end
    n_checks++; if (rs_inrdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 0", rs_inrdy); end
    n_checks++; if (rs_rdv !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_valid: got %b want 0", rs_rdv); end
    n_checks++; if (rs_rdd !== 8'h00) begin n_fail++; $display("FAIL rstmid_rd_data: got %h want 00", rs_rdd); end
    preset_chain();
    run_op(1'b0, -1, 0, -1, 0, -1, 1'b0);
    n_checks++; if (shift_q.size() !== 6) begin n_fail++; $display("FAIL rstmid_fresh_shifts: got %0d want 6", shift_q.size()); end
    n_checks++; if (done_cyc !== 8) begin n_fail++; $display("FAIL rstmid_fresh_done: got %0d want 8", done_cyc); end
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] g = (k < rb_q.size()) ? rb_q[k] : 'x;
      n_checks++; if (g !== DW'(8'hA5 - k)) begin n_fail++; $display("FAIL rstmid_readback[%0d]: got %h want %h", k, g, DW'(8'hA5 - k)); end
    end
  endtask

  task automatic test_back_to_back_start();
    preset_chain();
    run_op(1'b0, -1, 0, -1, 0, -1, 1'b1);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL restart_timeout: got %b want 0", timed_out); end
    n_checks++; if (shift_q.size() !== 6) begin n_fail++; $display("FAIL restart_shift_count: got %0d want 6", shift_q.size()); end
    n_checks++; if (inrdy_cnt !== 6) begin n_fail++; $display("FAIL restart_in_ready_count: got %0d want 6", inrdy_cnt); end
    n_checks++; if (done_cyc !== 8) begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 8", done_cyc); end
    for (int k = 0; k < CL; k++) begin
      n_checks++; if (chain[k] !== DW'(8'h15 - k)) begin n_fail++; $display("FAIL restart_chain[%0d]: got %h want %h", k, chain[k], DW'(8'h15 - k)); end
    end
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL restart_single_done: got %b want 0", bus.done_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL restart_busy_after: got %b want 0", bus.busy_o); end
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.mode_i     = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.rd_ready_i = 1'b1;
    test_reset();
    test_load();
    test_rotate();
    test_gap();
    test_stall();
    test_reset_mid();
    test_back_to_back_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
